block_dispatcher: RTL

- Sits directly upstream of the compute cores.
- Splits one kernel launch of thread_count threads into blocks of THREADS_PER_BLOCK and hands each block to a free core via start/block_id/thread_count.
- Watches each core's done, recycles finished cores with a one-cycle core reset, and raises done once every block has completed.

---
 rtl/dispatch_pkg.sv | 24 ++
 rtl/block_dispatcher_if.sv | 31 +++
 rtl/dispatch_slot.sv | 63 ++++++
 rtl/block_dispatcher.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the block dispatcher: slot/top FSM encodings,
// block-id width and the ceiling divide used to size a kernel launch.
package dispatch_pkg;

  localparam int BLOCK_ID_BITS = 8;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_BUSY,
    SLOT_CLEAR
  } slot_state_t;

  typedef enum logic [1:0] {
    DISP_IDLE,
    DISP_RUN,
    DISP_DONE
  } top_state_t;

  // 32-bit operands keep tc + den - 1 from overflowing at the top of the tc range.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/block_dispatcher_if.sv
// Dispatcher-to-core bus: per-core start/clear/block assignment out, done back.
// master = dispatcher side, slave = core array side.
interface block_dispatcher_if #(
  parameter int NUM_CORES = 2,
  parameter int CNT_BITS  = 3
);
  import dispatch_pkg::*;

  logic [NUM_CORES-1:0]                    core_start;
  logic [NUM_CORES-1:0]                    core_reset;
  logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0] core_block_id;
  logic [NUM_CORES-1:0][CNT_BITS-1:0]      core_thread_count;
  logic [NUM_CORES-1:0]                    core_done;

  modport master (
    output core_start,
    output core_reset,
    output core_block_id,
    output core_thread_count,
    input  core_done
  );

  modport slave (
    input  core_start,
    input  core_reset,
    input  core_block_id,
    input  core_thread_count,
    output core_done
  );

endinterface

// File: rtl/dispatch_slot.sv
// One core's slot: FREE -> BUSY on grant, BUSY -> CLEAR on core_done (one-cycle
// core reset plus completion pulse), CLEAR -> FREE on the following cycle.
module dispatch_slot
  import dispatch_pkg::*;
#(
  parameter int CNT_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     grant,
  input  logic                     core_done,
  input  logic [BLOCK_ID_BITS-1:0] block_id,
  input  logic [CNT_BITS-1:0]      thread_count,
  output logic                     free,
  output logic                     core_start,
  output logic                     core_reset,
  output logic [BLOCK_ID_BITS-1:0] core_block_id,
  output logic [CNT_BITS-1:0]      core_thread_count,
  output logic                     complete
);

  slot_state_t state_q, state_d;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      SLOT_FREE:  if (grant) state_d = SLOT_BUSY;
      SLOT_BUSY: begin
        if (core_done) begin
          state_d  = SLOT_CLEAR;
          complete = 1'b1;
        end
      end
      SLOT_CLEAR: state_d = SLOT_FREE;
      default:    state_d = SLOT_FREE;
    endcase
  end

  assign free       = (state_q == SLOT_FREE);
  assign core_start = (state_q == SLOT_BUSY);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= SLOT_FREE;
      core_reset        <= 1'b1;
      core_block_id     <= '0;
      core_thread_count <= '0;
    end else begin
      state_q    <= state_d;
      core_reset <= (state_d == SLOT_CLEAR);
      if (grant && state_q == SLOT_FREE) begin
        core_block_id     <= block_id;
        core_thread_count <= thread_count;
      end
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel launch into THREADS_PER_BLOCK-sized blocks and hands them to free
// cores, lowest index first. Optional kernel_cycles counter under DISPATCH_PERF_EN.
module block_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TC_BITS           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [TC_BITS-1:0] thread_count,
  output logic               done,
  output logic [31:0]        kernel_cycles,
  block_dispatcher_if.master cores
);

  localparam int CNT_BITS = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int TPB_LOG2 = $clog2(THREADS_PER_BLOCK);
  localparam int TOT_W    = TC_BITS + 1;
  localparam int REM_W    = TOT_W + TPB_LOG2 + 1;

  top_state_t state_q, state_d;

  logic [TC_BITS-1:0] tc_q;
  logic [TOT_W-1:0]   total_q, issued_q, completed_q, done_count;
  logic               launch, can_dispatch;
  logic [REM_W-1:0]   rem_threads;
  logic [CNT_BITS-1:0] blk_threads;

  logic [NUM_CORES-1:0] slot_free, grant, slot_complete, slot_start, slot_reset;
  logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0] slot_block_id;
  logic [NUM_CORES-1:0][CNT_BITS-1:0]      slot_tcount;

  assign launch       = (state_q == DISP_IDLE) && start;
  assign can_dispatch = (state_q == DISP_RUN) && (issued_q < total_q);
  assign done         = (state_q == DISP_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      DISP_IDLE: if (start) state_d = DISP_RUN;
      DISP_RUN:  if (completed_q == total_q) state_d = DISP_DONE;
      DISP_DONE: if (!start) state_d = DISP_IDLE;
      default:   state_d = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= DISP_IDLE;
    else        state_q <= state_d;
  end

  // Priority arbiter: scanning downward lets the lowest free index win.
  always_comb begin
    grant = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (can_dispatch && slot_free[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  // Threads left from the next block onward; only meaningful while issued < total.
  always_comb begin
    rem_threads = REM_W'(tc_q) - (REM_W'(issued_q) << TPB_LOG2);
    blk_threads = (rem_threads >= REM_W'(THREADS_PER_BLOCK)) ?
                  CNT_BITS'(THREADS_PER_BLOCK) : CNT_BITS'(rem_threads);
  end

  always_comb begin
    done_count = '0;
    for (int i = 0; i < NUM_CORES; i++) done_count = done_count + TOT_W'(slot_complete[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc_q        <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      completed_q <= '0;
    end else if (launch) begin
      tc_q        <= thread_count;
      total_q     <= TOT_W'(ceil_div(32'(thread_count), THREADS_PER_BLOCK));
      issued_q    <= '0;
      completed_q <= '0;
    end else begin
      if (|grant) issued_q <= issued_q + 1'b1;
      completed_q <= completed_q + done_count;
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    dispatch_slot #(
      .CNT_BITS(CNT_BITS)
    ) u_slot (
      .clk               (clk),
      .reset             (reset),
      .grant             (grant[i]),
      .core_done         (cores.core_done[i]),
      .block_id          (BLOCK_ID_BITS'(issued_q)),
      .thread_count      (blk_threads),
      .free              (slot_free[i]),
      .core_start        (slot_start[i]),
      .core_reset        (slot_reset[i]),
      .core_block_id     (slot_block_id[i]),
      .core_thread_count (slot_tcount[i]),
      .complete          (slot_complete[i])
    );
  end

  assign cores.core_start        = slot_start;
  assign cores.core_reset        = slot_reset;
  assign cores.core_block_id     = slot_block_id;
  assign cores.core_thread_count = slot_tcount;

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   perf_q <= '0;
    else if (launch)              perf_q <= '0;
    else if (state_q == DISP_RUN) perf_q <= perf_q + 32'd1;
  end

  assign kernel_cycles = perf_q;
`else
  assign kernel_cycles = '0;
`endif

endmodule
